// File: rtl/downmix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : downmix_pkg
// Description : Shared mode encodings, FSM state type and saturation helper
//               for the AXI-Stream channel downmixer.
// Revision    : 1.0 - initial release
// ============================================================================
package downmix_pkg;

    localparam logic [1:0] MODE_AVG = 2'b00;
    localparam logic [1:0] MODE_SEL = 2'b01;
    localparam logic [1:0] MODE_SUM = 2'b10;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_OUTPUT  = 2'd1,
        ST_OUTPUT2 = 2'd2
    } state_t;

    // Clamp a sign-extended value into the signed range of 'width' bits.
    function automatic logic signed [63:0] sat_clamp(
        input logic signed [63:0] value,
        input int                 width
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

    // The reserved encoding 2'b11 behaves as averaging.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return ((m == MODE_SEL) || (m == MODE_SUM)) ? m : MODE_AVG;
    endfunction

endpackage
`default_nettype wire

// File: rtl/downmix_saturate.sv
`default_nettype none
// ============================================================================
// Module      : downmix_saturate
// Description : Combinational clamp from accumulator width to DATA_WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module downmix_saturate
    import downmix_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int ACC_W      = 25
) (
    input  logic [ACC_W-1:0]      i_acc,
    output logic [DATA_WIDTH-1:0] o_sat
);

    logic signed [63:0] w_wide;
    logic signed [63:0] w_clamped;
    logic               w_unused_hi;

    assign w_wide      = {{(64-ACC_W){i_acc[ACC_W-1]}}, i_acc};
    assign w_clamped   = sat_clamp(w_wide, DATA_WIDTH);
    assign o_sat       = w_clamped[DATA_WIDTH-1:0];
    assign w_unused_hi = ^w_clamped[63:DATA_WIDTH];

endmodule
`default_nettype wire

// File: rtl/axis_channel_downmix.sv
`default_nettype none
// ============================================================================
// Module      : axis_channel_downmix
// Description : Folds CHANNELS interleaved AXI-Stream samples into one mono
//               sample (average / select / saturating sum). Optional macro
//               DOWNMIX_STEREO_DUP_EN emits each result as a two-beat frame.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_channel_downmix
    import downmix_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int OUT_WIDTH  = 24,
    parameter int CHANNELS   = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0]                  mode,
    input  logic [$clog2(CHANNELS)-1:0] sel,
    input  logic [DATA_WIDTH-1:0]       s_axis_data,
    input  logic                        s_axis_valid,
    output logic                        s_axis_ready,
    input  logic                        s_axis_last,
    output logic [OUT_WIDTH-1:0]        m_axis_data,
    output logic                        m_axis_valid,
    input  logic                        m_axis_ready,
    output logic                        m_axis_last,
    output logic                        frame_err
);

    localparam int              CH_W      = $clog2(CHANNELS);
    localparam int              ACC_W     = DATA_WIDTH + CH_W;
    localparam logic [CH_W-1:0] C_LAST_CH = CH_W'(CHANNELS - 1);
`ifdef DOWNMIX_STEREO_DUP_EN
    localparam logic            C_FIRST_LAST = 1'b0;
`else
    localparam logic            C_FIRST_LAST = 1'b1;
`endif

    state_t                  r_state;
    logic [CH_W-1:0]         r_ch;
    logic signed [ACC_W-1:0] r_acc;
    logic [1:0]              r_mode;
    logic [CH_W-1:0]         r_sel;
    logic [DATA_WIDTH-1:0]   r_sel_data;
    logic                    r_s_ready;
    logic                    r_m_valid;
    logic                    r_m_last;
    logic [OUT_WIDTH-1:0]    r_m_data;
    logic                    r_frame_err;

    logic                    w_beat;
    logic                    w_first;
    logic [1:0]              w_mode;
    logic [CH_W-1:0]         w_sel;
    logic                    w_sel_hit;
    logic signed [ACC_W-1:0] w_sample_ext;
    logic signed [ACC_W-1:0] w_acc_next;
    logic signed [ACC_W-1:0] w_avg_full;
    logic [DATA_WIDTH-1:0]   w_sel_val;
    logic [DATA_WIDTH-1:0]   w_sum;
    logic [DATA_WIDTH-1:0]   w_result;
    logic [OUT_WIDTH-1:0]    w_out;
    logic                    w_unused_bits;

    assign w_beat  = s_axis_valid && r_s_ready;
    assign w_first = (r_ch == '0);

    // Controls come straight from the ports on the first beat, then from the frame copy.
    assign w_mode    = norm_mode(w_first ? mode : r_mode);
    assign w_sel     = w_first ? sel : r_sel;
    assign w_sel_hit = (r_ch == w_sel);
    assign w_sel_val = w_sel_hit ? s_axis_data : r_sel_data;

    assign w_sample_ext = {{CH_W{s_axis_data[DATA_WIDTH-1]}}, s_axis_data};
    assign w_acc_next   = r_acc + w_sample_ext;
    assign w_avg_full   = w_acc_next >>> CH_W;

    downmix_saturate #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_W      (ACC_W)
    ) u_saturate (
        .i_acc (w_acc_next),
        .o_sat (w_sum)
    );

    always_comb begin
        w_result = w_avg_full[DATA_WIDTH-1:0];
        case (w_mode)
            MODE_SEL: w_result = w_sel_val;
            MODE_SUM: w_result = w_sum;
            default:  w_result = w_avg_full[DATA_WIDTH-1:0];
        endcase
    end

    assign w_out         = w_result[DATA_WIDTH-1 -: OUT_WIDTH];
    assign w_unused_bits = ^{w_avg_full[ACC_W-1:DATA_WIDTH], w_result};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_COLLECT;
            r_ch        <= '0;
            r_acc       <= '0;
            r_mode      <= MODE_AVG;
            r_sel       <= '0;
            r_sel_data  <= '0;
            r_s_ready   <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_m_data    <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                ST_COLLECT: begin
                    r_s_ready <= 1'b1;
                    if (w_beat) begin
                        if (w_first) begin
                            r_mode <= w_mode;
                            r_sel  <= sel;
                        end
                        if (w_sel_hit) begin
                            r_sel_data <= s_axis_data;
                        end
                        if (r_ch == C_LAST_CH) begin
                            r_ch  <= '0;
                            r_acc <= '0;
                            if (s_axis_last) begin
                                r_state   <= ST_OUTPUT;
                                r_s_ready <= 1'b0;
                                r_m_valid <= 1'b1;
                                r_m_last  <= C_FIRST_LAST;
                                r_m_data  <= w_out;
                            end else begin
                                r_frame_err <= 1'b1;
                            end
                        end else if (s_axis_last) begin
                            // Early last: drop the partial frame.
                            r_ch        <= '0;
                            r_acc       <= '0;
                            r_frame_err <= 1'b1;
                        end else begin
                            r_ch  <= r_ch + CH_W'(1);
                            r_acc <= w_acc_next;
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (m_axis_ready) begin
`ifdef DOWNMIX_STEREO_DUP_EN
                        r_state  <= ST_OUTPUT2;
                        r_m_last <= 1'b1;
`else
                        r_state   <= ST_COLLECT;
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        r_s_ready <= 1'b1;
                        r_ch      <= '0;
                        r_acc     <= '0;
`endif
                    end
                end
                ST_OUTPUT2: begin
                    if (m_axis_ready) begin
                        r_state   <= ST_COLLECT;
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        r_s_ready <= 1'b1;
                        r_ch      <= '0;
                        r_acc     <= '0;
                    end
                end
                default: begin
                    r_state   <= ST_COLLECT;
                    r_m_valid <= 1'b0;
                    r_m_last  <= 1'b0;
                    r_s_ready <= 1'b1;
                end
            endcase
        end
    end

    assign s_axis_ready = r_s_ready;
    assign m_axis_valid = r_m_valid;
    assign m_axis_last  = r_m_last;
    assign m_axis_data  = r_m_data;
    assign frame_err    = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_axis_channel_downmix.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_channel_downmix
// Description : Scoreboard bench for axis_channel_downmix (24/24/2 config).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_channel_downmix;

    localparam int DW = 24;
    localparam int OW = 24;
    localparam int CH = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    mode = 2'b00;
    logic [0:0]    sel = 1'b0;
    logic [DW-1:0] s_axis_data = '0;
    logic          s_axis_valid = 1'b0;
    logic          s_axis_ready;
    logic          s_axis_last = 1'b0;
    logic [OW-1:0] m_axis_data;
    logic          m_axis_valid;
    logic          m_axis_ready = 1'b0;
    logic          m_axis_last;
    logic          frame_err;

    axis_channel_downmix #(
        .DATA_WIDTH (DW),
        .OUT_WIDTH  (OW),
        .CHANNELS   (CH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mode         (mode),
        .sel          (sel),
        .s_axis_data  (s_axis_data),
        .s_axis_valid (s_axis_valid),
        .s_axis_ready (s_axis_ready),
        .s_axis_last  (s_axis_last),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready),
        .m_axis_last  (m_axis_last),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] d;
        logic          l;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_err_seen = 0;
    int   n_err_exp = 0;
    int   ready_mode = 1;   // 0 random, 1 always high, 2 always low
    logic rst_at_edge = 1'b1;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the frame's sample values.
    function automatic logic [OW-1:0] model(input int m, input int s,
                                            input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint va, vb, sum, r, maxv, minv;
        logic [63:0] rv;
        va   = longint'($signed(a));
        vb   = longint'($signed(b));
        sum  = va + vb;
        maxv = (longint'(1) << (DW - 1)) - 1;
        minv = -(longint'(1) << (DW - 1));
        case (m)
            1: r = (s == 0) ? va : vb;
            2: r = (sum > maxv) ? maxv : ((sum < minv) ? minv : sum);
            default: begin
                r = sum / CH;
                if (sum < 0 && (sum % CH) != 0) r = r - 1;
            end
        endcase
        rv = r;
        return rv[DW-1 -: OW];
    endfunction

    task automatic push_exp(input logic [OW-1:0] d);
        exp_t e;
`ifdef DOWNMIX_STEREO_DUP_EN
        e.d = d; e.l = 1'b0; exp_q.push_back(e);
`endif
        e.d = d; e.l = 1'b1; exp_q.push_back(e);
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        int budget;
        @(negedge clk);
        s_axis_data  = d;
        s_axis_last  = l;
        s_axis_valid = 1'b1;
        budget = 0;
        while (!s_axis_ready && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        if (!s_axis_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL s_ready_timeout: got ready=0 required ready=1 within 1000 cycles");
        end
        @(posedge clk);
        #1 s_axis_valid = 1'b0;
    endtask

    // kind: 0 good frame, 1 early last, 2 missing last. exp_val<0 uses the model.
    task automatic send_frame(input int m, input int s, input logic [DW-1:0] a,
                              input logic [DW-1:0] b, input int kind, input longint exp_val);
        logic [63:0] ev;
        if (kind == 0) begin
            ev = exp_val;
            push_exp((exp_val < 0) ? model(m, s, a, b) : ev[OW-1:0]);
        end else begin
            n_err_exp++;
        end
        mode = m[1:0];
        sel  = s[0:0];
        if (kind == 1) begin
            send_beat(a, 1'b1);
        end else begin
            send_beat(a, 1'b0);
            mode = 2'($urandom_range(0, 3));
            sel  = 1'($urandom_range(0, 1));
            send_beat(b, (kind == 0));
        end
    endtask

    function automatic logic [DW-1:0] rnd_sample();
        case ($urandom_range(0, 7))
            0: return 24'h7FFFFF;
            1: return 24'h800000;
            2: return 24'hFFFFFF;
            3: return 24'h000000;
            default: return DW'($urandom);
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            rst_at_edge = reset;
            #2;
            case (ready_mode)
                0: m_axis_ready = ($urandom_range(0, 3) != 0);
                1: m_axis_ready = 1'b1;
                default: m_axis_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        logic          prev_stall;
        logic [OW-1:0] pd;
        logic          pl;
        exp_t          e;
        prev_stall = 1'b0;
        pd = '0;
        pl = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_at_edge) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", m_axis_valid, 1);
                    check("stall_data", m_axis_data, pd);
                    check("stall_last", m_axis_last, pl);
                end
                if (m_axis_valid && m_axis_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got data 0x%0h with nothing expected", m_axis_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", m_axis_data, e.d);
                        check("out_last", m_axis_last, e.l);
                    end
                end
                prev_stall = m_axis_valid && !m_axis_ready;
                pd = m_axis_data;
                pl = m_axis_last;
                if (frame_err) n_err_seen++;
            end
        end
    end

    initial begin
        int budget;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", m_axis_valid, 0);
        check("rst_last", m_axis_last, 0);
        check("rst_data", m_axis_data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_s_ready", s_axis_ready, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("ready_after_reset", s_axis_ready, 1);

        // Average with one-cycle latency
        ready_mode = 1;
        send_frame(0, 0, 24'h000100, 24'h000300, 0, 24'h000200);
        @(negedge clk);
        check("latency_valid", m_axis_valid, 1);
        repeat (3) @(negedge clk);

        // Saturation and floor-rounding boundaries
        send_frame(2, 0, 24'h7FFFFF, 24'h000001, 0, 24'h7FFFFF);
        send_frame(2, 0, 24'h800000, 24'h800000, 0, 24'h800000);
        send_frame(0, 0, 24'hFFFFFF, 24'h000000, 0, 24'hFFFFFF);
        send_frame(3, 1, 24'h000005, 24'h000002, 0, 24'h000003);

        // Select with sel toggled after the first beat
        push_exp(24'h654321);
        mode = 2'b01;
        sel  = 1'b1;
        send_beat(24'h123456, 1'b0);
        sel  = 1'b0;
        mode = 2'b10;
        send_beat(24'h654321, 1'b1);

        // Early last, then a good frame
        send_frame(0, 0, 24'h000010, 24'h0, 1, -1);
        @(negedge clk);
        check("early_err_pulse", frame_err, 1);
        @(negedge clk);
        check("early_err_clear", frame_err, 0);
        send_frame(0, 0, 24'h000002, 24'h000004, 0, 24'h000003);

        // Missing last, then a good frame
        send_frame(0, 0, 24'h000040, 24'h000050, 2, -1);
        send_frame(0, 0, 24'h000006, 24'h00000A, 0, 24'h000008);

        // Reset mid-frame: no output, no error, next frame starts clean
        repeat (4) @(negedge clk);
        mode = 2'b00;
        send_beat(24'h000777, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        send_frame(0, 0, 24'h000020, 24'h000040, 0, 24'h000030);
        repeat (4) @(negedge clk);

        // Back-pressure then reset while a result is pending
        ready_mode = 2;
        send_frame(0, 0, 24'h000100, 24'h000300, 0, 24'h000200);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("bp_s_ready", s_axis_ready, 0);
            check("bp_valid", m_axis_valid, 1);
        end
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("bp_reset_valid", m_axis_valid, 0);
        check("bp_reset_err", frame_err, 0);
        @(negedge clk);
        reset = 1'b0;
        ready_mode = 1;
        repeat (8) @(negedge clk);

        // Randomized frames against the model
        ready_mode = 0;
        for (int f = 0; f < 250; f++) begin
            int kind;
            int r;
            r = $urandom_range(0, 9);
            kind = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
            send_frame($urandom_range(0, 3), $urandom_range(0, CH - 1),
                       rnd_sample(), rnd_sample(), kind, -1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        ready_mode = 1;
        budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("frame_err_count", n_err_seen, n_err_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
